// File: rtl/intpol2_pkg.sv
// Shared definitions for the quadratic-interpolator controller slice.
// - mode_e        : operating mode encoding (interpolate / pass-through)
// - m_cnt_width() : bit width of the coefficient-load sequence counter
// - sel_xi_width(): bit width of the history-tap select output
package intpol2_pkg;

  typedef enum logic {
    MODE_INTERP = 1'b0,
    MODE_BYPASS = 1'b1
  } mode_e;

  // m_cnt walks 0..num_m, so it needs room for num_m+1 distinct values.
  function automatic int unsigned m_cnt_width(input int unsigned num_m);
    return $clog2(num_m + 1);
  endfunction

  // sel_xi saturates at num_m, so it must be able to represent num_m itself.
  function automatic int unsigned sel_xi_width(input int unsigned num_m);
    return $clog2(num_m + 1);
  endfunction

endpackage

// File: rtl/intpol2_mod_cnt.sv
// Modulo-N up-counter with synchronous clear and enable.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear (same effect as rst)
//   en   : advance the count, wrapping from N-1 back to 0
//   cnt  : current count value (0..N-1)
//   wrap : count is sitting at its terminal value N-1
module intpol2_mod_cnt #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign wrap = (cnt == LAST);

endmodule

// File: rtl/intpol2_dn_ctrl.sv
// Sequencing / next-state controller for the 2nd-order interpolator datapath.
// Tracks input samples against the programmed run length, sequences the
// coefficient-register loads, selects the history tap while the pipeline is
// priming, generates the interpolation phase and registers the FIFO-bypass
// decision.
// Parameters:
//   DATA_WIDTH : sample counter and ilen are DATA_WIDTH+1 bits
//   LOG2_D     : interpolation factor D = 2**LOG2_D (>= 1)
//   NUM_M      : coefficient registers loaded per sample (>= 2)
// Ports:
//   clk, rst, clear : clock, sync active-high reset, sync soft clear
//   mode            : 0 interpolate, 1 pass-through (phase held at 0)
//   empty, afull    : FIFO status
//   busy            : datapath active
//   en_sum          : advance sample counter
//   en_m_addr       : run coefficient-load sequencer (0 holds it at 0)
//   phase_en        : advance interpolation phase
//   done            : end of run, clears sample counter and phase
//   ilen            : samples in run
//   comp_cnt        : last sample reached
//   comp_addr       : last coefficient load this cycle
//   ld_m            : one-hot coefficient load strobes
//   sel_xi          : history-tap select, min(cnt+1, NUM_M)
//   phase           : current interpolation phase
//   phase_wrap      : final phase of the current sample
//   fifo_bypass     : registered bypass decision
module intpol2_dn_ctrl
  import intpol2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2_D     = 2,
  parameter int unsigned NUM_M      = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             mode,
  input  logic                             empty,
  input  logic                             afull,
  input  logic                             busy,
  input  logic                             en_sum,
  input  logic                             en_m_addr,
  input  logic                             phase_en,
  input  logic                             done,
  input  logic [DATA_WIDTH:0]              ilen,
  output logic                             comp_cnt,
  output logic                             comp_addr,
  output logic [NUM_M-1:0]                 ld_m,
  output logic [sel_xi_width(NUM_M)-1:0]   sel_xi,
  output logic [LOG2_D-1:0]                phase,
  output logic                             phase_wrap,
  output logic                             fifo_bypass
);

  localparam int unsigned CW = DATA_WIDTH + 1;
  localparam int unsigned MW = m_cnt_width(NUM_M);
  localparam int unsigned SW = sel_xi_width(NUM_M);
  localparam int unsigned D  = 1 << LOG2_D;

  // History is primed once cnt reaches NUM_M-1; sel_xi saturates from there.
  localparam logic [CW-1:0] SEL_SAT_AT = CW'(NUM_M - 1);
  localparam logic [SW-1:0] SEL_MAX    = SW'(NUM_M);

  logic [CW-1:0] cnt;
  logic [MW-1:0] m_cnt;
  logic          m_last;
  logic          ph_last;
  logic          bypass_mode;

  assign bypass_mode = (mode == MODE_BYPASS);

  // Sample counter: done outranks en_sum; wraps naturally at 2**CW.
  always_ff @(posedge clk) begin
    if (rst || clear || done) begin
      cnt <= '0;
    end else if (en_sum) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Coefficient-load sequencer: 0,1..NUM_M,0,... while enabled, parked at 0
  // otherwise. done does not touch it.
  intpol2_mod_cnt #(
    .N (NUM_M + 1),
    .W (MW)
  ) u_m_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear || !en_m_addr),
    .en   (en_m_addr),
    .cnt  (m_cnt),
    .wrap (m_last)
  );

  // Interpolation phase: pass-through mode pins it to 0 on the next edge.
  intpol2_mod_cnt #(
    .N (D),
    .W (LOG2_D)
  ) u_phase_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear || done || bypass_mode),
    .en   (phase_en),
    .cnt  (phase),
    .wrap (ph_last)
  );

  // ilen==0 would underflow ilen-1; treat an empty run as already complete.
  assign comp_cnt = (ilen == '0) ? 1'b1 : (cnt >= (ilen - 1'b1));

  assign sel_xi = (cnt >= SEL_SAT_AT) ? SEL_MAX : SW'(cnt + 1'b1);

  always_comb begin
    ld_m = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      ld_m[k] = (m_cnt == MW'(k + 1));
    end
  end

  // m_cnt at its terminal value NUM_M is exactly ld_m[NUM_M-1].
  assign comp_addr = m_last;

  // In pass-through every enabled phase is the final one (D behaves as 1).
  assign phase_wrap = phase_en && (bypass_mode || ph_last);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fifo_bypass <= 1'b0;
    end else begin
      fifo_bypass <= busy && !empty && !afull;
    end
  end

endmodule

// File: tb/tb_intpol2_dn_ctrl.sv
module tb_intpol2_dn_ctrl;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LOG2_D     = 2;
  localparam int unsigned NUM_M      = 3;
  localparam int unsigned D          = 1 << LOG2_D;
  localparam longint unsigned CMOD   = 64'd1 << (DATA_WIDTH + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  clear = 1'b0;
  logic                  mode = 1'b0;
  logic                  empty = 1'b1;
  logic                  afull = 1'b0;
  logic                  busy = 1'b0;
  logic                  en_sum = 1'b0;
  logic                  en_m_addr = 1'b0;
  logic                  phase_en = 1'b0;
  logic                  done = 1'b0;
  logic [DATA_WIDTH:0]   ilen = 33'd5;
  logic                  comp_cnt;
  logic                  comp_addr;
  logic [NUM_M-1:0]      ld_m;
  logic [1:0]            sel_xi;
  logic [LOG2_D-1:0]     phase;
  logic                  phase_wrap;
  logic                  fifo_bypass;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers, updated per clock edge)
  longint unsigned mdl_cnt = 0;
  int unsigned     mdl_m   = 0;
  int unsigned     mdl_ph  = 0;
  bit              mdl_byp = 0;

  intpol2_dn_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_D     (LOG2_D),
    .NUM_M      (NUM_M)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .mode        (mode),
    .empty       (empty),
    .afull       (afull),
    .busy        (busy),
    .en_sum      (en_sum),
    .en_m_addr   (en_m_addr),
    .phase_en    (phase_en),
    .done        (done),
    .ilen        (ilen),
    .comp_cnt    (comp_cnt),
    .comp_addr   (comp_addr),
    .ld_m        (ld_m),
    .sel_xi      (sel_xi),
    .phase       (phase),
    .phase_wrap  (phase_wrap),
    .fifo_bypass (fifo_bypass)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model sees the same inputs the DUT sampled.
  task automatic cyc();
    @(posedge clk);
    if (rst || clear) begin
      mdl_cnt = 0; mdl_m = 0; mdl_ph = 0; mdl_byp = 0;
    end else begin
      if (done) mdl_cnt = 0;
      else if (en_sum) mdl_cnt = (mdl_cnt + 1) % CMOD;
      if (!en_m_addr) mdl_m = 0;
      else mdl_m = (mdl_m + 1) % (NUM_M + 1);
      if (done || mode) mdl_ph = 0;
      else if (phase_en) mdl_ph = (mdl_ph + 1) % D;
      mdl_byp = busy && !empty && !afull;
    end
    #1;
  endtask

  function automatic bit exp_comp_cnt();
    longint unsigned il = longint'(ilen);
    return (il == 0) ? 1'b1 : (mdl_cnt >= il - 1);
  endfunction

  function automatic int unsigned exp_sel();
    return (mdl_cnt + 1 < NUM_M) ? int'(mdl_cnt + 1) : NUM_M;
  endfunction

  function automatic int unsigned exp_ld();
    return (mdl_m == 0) ? 0 : (1 << (mdl_m - 1));
  endfunction

  task automatic test_reset();
    rst = 1'b1; ilen = 33'd5;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    checks++; if (sel_xi !== 2'd1) begin errors++; $display("FAIL reset_sel_xi got %0d exp 1", sel_xi); end
    checks++; if (ld_m !== 3'b000) begin errors++; $display("FAIL reset_ld_m got %b exp 000", ld_m); end
    checks++; if (comp_cnt !== 1'b0) begin errors++; $display("FAIL reset_comp_cnt got %b exp 0", comp_cnt); end
    checks++; if (comp_addr !== 1'b0) begin errors++; $display("FAIL reset_comp_addr got %b exp 0", comp_addr); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if (fifo_bypass !== 1'b0) begin errors++; $display("FAIL reset_fifo_bypass got %b exp 0", fifo_bypass); end
    checks++; if (phase_wrap !== 1'b0) begin errors++; $display("FAIL reset_phase_wrap got %b exp 0", phase_wrap); end
  endtask

  task automatic test_cnt();
    logic [1:0] sel_tbl [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       cc_tbl  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (sel_xi !== sel_tbl[i]) begin errors++; $display("FAIL cnt_sel_xi[%0d] got %0d exp %0d", i, sel_xi, sel_tbl[i]); end
      checks++; if (comp_cnt !== cc_tbl[i]) begin errors++; $display("FAIL cnt_comp_cnt[%0d] got %b exp %b", i, comp_cnt, cc_tbl[i]); end
      if (i < 4) begin
        en_sum = 1'b1; cyc(); en_sum = 1'b0;
      end
    end
  endtask

  task automatic test_m_addr();
    logic [2:0] ld_tbl [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
    en_m_addr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ld_m !== ld_tbl[i]) begin errors++; $display("FAIL m_addr_ld_m[%0d] got %b exp %b", i, ld_m, ld_tbl[i]); end
      checks++; if (comp_addr !== (i == 3)) begin errors++; $display("FAIL m_addr_comp_addr[%0d] got %b exp %b", i, comp_addr, (i == 3)); end
      cyc();
    end
    en_m_addr = 1'b0;
    cyc();
  endtask

  task automatic test_phase();
    logic [1:0] ep;
    mode = 1'b0; phase_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ep = 2'(i % 4);
      #1;
      checks++; if (phase !== ep) begin errors++; $display("FAIL phase_seq[%0d] got %0d exp %0d", i, phase, ep); end
      checks++; if (phase_wrap !== (ep == 2'd3)) begin errors++; $display("FAIL phase_wrap_seq[%0d] got %b exp %b", i, phase_wrap, (ep == 2'd3)); end
      cyc();
    end
    mode = 1'b1;
    #1;
    checks++; if (phase !== 2'd3) begin errors++; $display("FAIL phase_before_bypass got %0d exp 3", phase); end
    checks++; if (phase_wrap !== 1'b1) begin errors++; $display("FAIL phase_wrap_bypass_now got %b exp 1", phase_wrap); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (phase !== 2'd0) begin errors++; $display("FAIL phase_bypass[%0d] got %0d exp 0", i, phase); end
      checks++; if (phase_wrap !== 1'b1) begin errors++; $display("FAIL phase_wrap_bypass[%0d] got %b exp 1", i, phase_wrap); end
      cyc();
    end
    mode = 1'b0; phase_en = 1'b0;
    cyc();
  endtask

  task automatic test_bypass();
    logic prev;
    busy = 1'b1; afull = 1'b0; empty = 1'b1;
    cyc();
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      empty = (i % 2 == 0) ? 1'b0 : 1'b1;
      #1;
      checks++; if (fifo_bypass !== prev) begin errors++; $display("FAIL bypass_lag[%0d] got %b exp %b", i, fifo_bypass, prev); end
      cyc();
      checks++; if (fifo_bypass !== !empty) begin errors++; $display("FAIL bypass_follow[%0d] got %b exp %b", i, fifo_bypass, !empty); end
      prev = !empty;
    end
    afull = 1'b1; empty = 1'b0;
    cyc();
    checks++; if (fifo_bypass !== 1'b0) begin errors++; $display("FAIL bypass_afull got %b exp 0", fifo_bypass); end
    busy = 1'b0; afull = 1'b0; empty = 1'b1;
    cyc();
  endtask

  task automatic test_done_clear();
    ilen = 33'd5;
    en_sum = 1'b1; phase_en = 1'b1;
    cyc(); cyc();
    done = 1'b1;
    cyc();
    done = 1'b0; en_sum = 1'b0; phase_en = 1'b0;
    #1;
    checks++; if (sel_xi !== 2'd1) begin errors++; $display("FAIL done_sel_xi got %0d exp 1", sel_xi); end
    checks++; if (comp_cnt !== 1'b0) begin errors++; $display("FAIL done_comp_cnt got %b exp 0", comp_cnt); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL done_phase got %0d exp 0", phase); end
    en_m_addr = 1'b1; en_sum = 1'b1; phase_en = 1'b1;
    cyc(); cyc();
    checks++; if (ld_m !== 3'b010) begin errors++; $display("FAIL pre_clear_ld_m got %b exp 010", ld_m); end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    #1;
    checks++; if (sel_xi !== 2'd1) begin errors++; $display("FAIL clear_sel_xi got %0d exp 1", sel_xi); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL clear_phase got %0d exp 0", phase); end
    checks++; if (ld_m !== 3'b000) begin errors++; $display("FAIL clear_ld_m got %b exp 000", ld_m); end
    checks++; if (comp_addr !== 1'b0) begin errors++; $display("FAIL clear_comp_addr got %b exp 0", comp_addr); end
    en_m_addr = 1'b0; en_sum = 1'b0; phase_en = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    int unsigned e_sel;
    int unsigned e_ld;
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clear     = ($urandom_range(0, 99) == 0);
      done      = ($urandom_range(0, 29) == 0);
      mode      = ($urandom_range(0, 7) == 0);
      en_sum    = 1'($urandom);
      en_m_addr = ($urandom_range(0, 5) != 0);
      phase_en  = 1'($urandom);
      busy      = 1'($urandom);
      empty     = 1'($urandom);
      afull     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) ilen = {1'($urandom), 32'($urandom)};
      else if ($urandom_range(0, 9) == 0) ilen = 33'($urandom_range(0, 12));
      #1;
      e_sel = exp_sel();
      e_ld  = exp_ld();
      checks++; if (comp_cnt !== exp_comp_cnt()) begin errors++; $display("FAIL rnd_comp_cnt[%0d] got %b exp %b", n, comp_cnt, exp_comp_cnt()); end
      checks++; if (sel_xi !== 2'(e_sel)) begin errors++; $display("FAIL rnd_sel_xi[%0d] got %0d exp %0d", n, sel_xi, e_sel); end
      checks++; if (ld_m !== 3'(e_ld)) begin errors++; $display("FAIL rnd_ld_m[%0d] got %b exp %0d", n, ld_m, e_ld); end
      checks++; if (comp_addr !== (mdl_m == NUM_M)) begin errors++; $display("FAIL rnd_comp_addr[%0d] got %b exp %b", n, comp_addr, (mdl_m == NUM_M)); end
      checks++; if (phase !== 2'(mdl_ph)) begin errors++; $display("FAIL rnd_phase[%0d] got %0d exp %0d", n, phase, mdl_ph); end
      checks++; if (phase_wrap !== (phase_en && (mode || mdl_ph == D - 1))) begin
        errors++; $display("FAIL rnd_phase_wrap[%0d] got %b exp %b", n, phase_wrap, (phase_en && (mode || mdl_ph == D - 1)));
      end
      checks++; if (fifo_bypass !== mdl_byp) begin errors++; $display("FAIL rnd_fifo_bypass[%0d] got %b exp %b", n, fifo_bypass, mdl_byp); end
      cyc();
    end
    rst = 1'b0; clear = 1'b0; done = 1'b0; mode = 1'b0;
    en_sum = 1'b0; en_m_addr = 1'b0; phase_en = 1'b0; busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cnt();
    test_m_addr();
    test_phase();
    test_bypass();
    test_done_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
